// File: rtl/crc_check.sv
// Receive-side CRC checker: strips the FCS trailer from each packet, forwards
// the payload with the last flag moved onto the final payload word, and pulses
// a per-packet pass/fail/runt status.
module crc_check #(
  parameter int                  CRC_SIZE    = 16,
  parameter int                  DATA_WIDTH  = 8,
  parameter logic [CRC_SIZE-1:0] POLY        = 16'h8005,
  parameter logic [CRC_SIZE-1:0] INIT        = 16'h0000,
  parameter string               REF_IN      = "TRUE",
  parameter string               REF_OUT     = "TRUE",
  parameter logic [CRC_SIZE-1:0] XOR_OUT     = 16'hFFFF,
  parameter string               FCS_LSB_1ST = "TRUE"
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  status_valid_o,
  output logic                  crc_ok_o,
  output logic                  runt_o
);

  // Number of stream words that make up the FCS trailer.
  localparam int D  = CRC_SIZE / DATA_WIDTH;
  localparam int FW = $clog2(D + 1);
  localparam logic [FW-1:0] D_CNT = FW'(D);

  localparam bit REF_IN_EN  = (REF_IN == "TRUE");
  localparam bit REF_OUT_EN = (REF_OUT == "TRUE");
  localparam bit FCS_LSB_EN = (FCS_LSB_1ST == "TRUE");

  // The trailer must be a whole number of words and fit the 64-bit limit.
  if ((CRC_SIZE % DATA_WIDTH) != 0 || CRC_SIZE > 64 || CRC_SIZE < DATA_WIDTH) begin : g_bad_size
    $error("crc_check: CRC_SIZE must be a multiple of DATA_WIDTH and at most 64");
  end

  typedef enum logic {
    RUN   = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] dly [D];
  logic [FW-1:0]         fill;
  logic [CRC_SIZE-1:0]   crc;
  logic                  runt_q;
  logic                  accept;
  logic [CRC_SIZE-1:0]   fcs;
  logic [CRC_SIZE-1:0]   crc_final;

  function automatic logic [DATA_WIDTH-1:0] reflect_word(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = v[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  function automatic logic [CRC_SIZE-1:0] reflect_crc(input logic [CRC_SIZE-1:0] v);
    logic [CRC_SIZE-1:0] r;
    for (int i = 0; i < CRC_SIZE; i++) begin
      r[i] = v[CRC_SIZE-1-i];
    end
    return r;
  endfunction

  // One full word through the MSB-first CRC register; reflection of the input
  // word is done up front so the register itself is always non-reflected.
  function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0] c,
                                                   input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] d;
    logic [CRC_SIZE-1:0]   r;
    logic                  fb;
    d = REF_IN_EN ? reflect_word(w) : w;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = r[CRC_SIZE-1] ^ d[i];
      r  = r << 1;
      if (fb) begin
        r = r ^ POLY;
      end
    end
    return r;
  endfunction

  assign accept = s_valid_i & s_ready_o;

  // Assemble the received FCS from the delay line and finish the computed CRC.
  always_comb begin
    fcs = '0;
    for (int i = 0; i < D; i++) begin
      if (FCS_LSB_EN) begin
        fcs[i*DATA_WIDTH +: DATA_WIDTH] = dly[i];
      end else begin
        fcs[(D-1-i)*DATA_WIDTH +: DATA_WIDTH] = dly[i];
      end
    end
    crc_final = (REF_OUT_EN ? reflect_crc(crc) : crc) ^ XOR_OUT;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state, input backpressure and the one-cycle status pulse.
  always_comb begin
    state_next     = state;
    s_ready_o      = 1'b0;
    status_valid_o = 1'b0;
    crc_ok_o       = 1'b0;
    runt_o         = 1'b0;
    case (state)
      RUN: begin
        s_ready_o = (fill < D_CNT) | ~m_valid_o | m_ready_i;
        if (s_valid_i & s_ready_o & s_last_i) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        status_valid_o = 1'b1;
        runt_o         = runt_q;
        crc_ok_o       = (crc_final == fcs) & ~runt_q;
        state_next     = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Delay line, fill counter, CRC accumulation and the registered payload output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill      <= '0;
      crc       <= INIT;
      runt_q    <= 1'b0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
    end else begin
      if (m_valid_o & m_ready_i) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end
      if (state == CHECK) begin
        crc  <= INIT;
        fill <= '0;
      end else if (accept) begin
        for (int i = 0; i < D - 1; i++) begin
          dly[i] <= dly[i+1];
        end
        dly[D-1] <= s_data_i;
        if (fill < D_CNT) begin
          fill <= fill + FW'(1);
        end else begin
          m_data_o  <= dly[0];
          m_valid_o <= 1'b1;
          m_last_o  <= s_last_i;
          crc       <= crc_step(crc, dly[0]);
        end
        if (s_last_i) begin
          runt_q <= (fill < D_CNT);
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: a CRC-16/MAXIM instance and a
// CRC-16/BUYPASS instance share one stimulus stream; one of them is observed.
module tb_crc_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_ready;
  logic [1:0] s_ready;
  logic [1:0] m_valid;
  logic [1:0] m_last;
  logic [1:0] status_valid;
  logic [1:0] crc_ok;
  logic [1:0] runt;
  logic [7:0] m_data [2];

  int vectors      = 0;
  int miscompares  = 0;
  int cyc          = 0;
  int sel          = 0;
  int stall_mode   = 0;
  int beats_in_pkt = 0;

  logic [7:0] out_d [$];
  logic       out_l [$];
  logic       st_ok [$];
  logic       st_runt [$];
  int         st_cyc [$];

  typedef struct {
    int         sel;
    int         len;
    logic [7:0] data [16];
    int         stall;
    bit         exp_ok;
    bit         exp_runt;
  } vec_t;

  vec_t tbl [$];

  crc_check dut0 (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready[0]), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid[0]), .m_ready_i(m_ready), .m_data_o(m_data[0]), .m_last_o(m_last[0]),
    .status_valid_o(status_valid[0]), .crc_ok_o(crc_ok[0]), .runt_o(runt[0])
  );

  crc_check #(
    .REF_IN("FALSE"), .REF_OUT("FALSE"), .XOR_OUT(16'h0000), .FCS_LSB_1ST("FALSE")
  ) dut1 (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready[1]), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid[1]), .m_ready_i(m_ready), .m_data_o(m_data[1]), .m_last_o(m_last[1]),
    .status_valid_o(status_valid[1]), .crc_ok_o(crc_ok[1]), .runt_o(runt[1])
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time status pulses and pace the consumer.
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: always ready, or ready one cycle in three when stalling.
  always @(posedge clk) begin
    #1;
    m_ready = (stall_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: records consumed payload and status pulses, and checks backpressure.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid[sel] && m_ready) begin
        out_d.push_back(m_data[sel]);
        out_l.push_back(m_last[sel]);
      end
      if (status_valid[sel]) begin
        st_ok.push_back(crc_ok[sel]);
        st_runt.push_back(runt[sel]);
        st_cyc.push_back(cyc);
      end
      if (beats_in_pkt >= 2) begin
        checkOutput("s_ready_backpressure", 32'(s_ready[sel]), 32'(!m_valid[sel] || m_ready));
      end
    end
  end

  // Reference CRC over a whole payload: reflected shift-right form for MAXIM,
  // plain shift-left form for BUYPASS.
  function automatic logic [15:0] model_crc(input int s, input logic [7:0] d [$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (d[k]) begin
      if (s == 0) begin
        c = c ^ {8'h00, d[k]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end else begin
        c = c ^ {d[k], 8'h00};
        for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
      end
    end
    return (s == 0) ? (c ^ 16'hFFFF) : c;
  endfunction

  task automatic append_fcs(input int s, input logic [7:0] pay [$], output logic [7:0] q [$]);
    logic [15:0] c;
    q = pay;
    c = model_crc(s, pay);
    if (s == 0) begin
      q.push_back(c[7:0]);
      q.push_back(c[15:8]);
    end else begin
      q.push_back(c[15:8]);
      q.push_back(c[7:0]);
    end
  endtask

  task automatic add_vec(input int s, input string pay, input int tr, input logic [7:0] t0,
                         input logic [7:0] t1, input int st, input bit ok, input bit rn);
    vec_t       v;
    logic [7:0] q [$];
    logic [7:0] p [$];
    for (int k = 0; k < pay.len(); k++) p.push_back(pay[k]);
    if (tr == 2) begin
      append_fcs(s, p, q);
    end else begin
      q = p;
      if (tr == 1) begin
        q.push_back(t0);
        q.push_back(t1);
      end
    end
    v.sel = s;
    v.len = q.size();
    for (int k = 0; k < 16; k++) v.data[k] = (k < q.size()) ? q[k] : 8'h00;
    v.stall    = st;
    v.exp_ok   = ok;
    v.exp_runt = rn;
    tbl.push_back(v);
  endtask

  // Drive one packet beat by beat, honouring s_ready; with_last marks the final beat.
  task automatic applyStimulus(input logic [7:0] pk [$], input bit with_last);
    bit acc;
    int waited;
    for (int i = 0; i < pk.size(); i++) begin
      s_valid = 1'b1;
      s_data  = pk[i];
      s_last  = with_last && (i == pk.size() - 1);
      acc     = 1'b0;
      waited  = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready[sel];
        @(posedge clk);
        #1;
        waited++;
        if (!acc && waited > 40) begin
          miscompares++;
          vectors++;
          $display("[TB] FAIL s_ready_timeout: got 0 expected 1 within 40 cycles");
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
      beats_in_pkt = s_last ? 0 : beats_in_pkt + 1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (with_last) begin
      @(negedge clk);
      checkOutput("status_timing", 32'(status_valid[sel]), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    out_d.delete();
    out_l.delete();
    st_ok.delete();
    st_runt.delete();
    st_cyc.delete();
  endtask

  task automatic checkPacket(input string nm, input logic [7:0] exp [$], input bit ok, input bit rn);
    int nbad;
    int nbadl;
    nbad  = 0;
    nbadl = 0;
    checkOutput({nm, ".count"}, out_d.size(), exp.size());
    for (int k = 0; k < out_d.size() && k < exp.size(); k++) begin
      if (out_d[k] !== exp[k]) nbad++;
      if (out_l[k] !== (k == exp.size() - 1)) nbadl++;
    end
    checkOutput({nm, ".data_errs"}, nbad, 0);
    checkOutput({nm, ".last_errs"}, nbadl, 0);
    checkOutput({nm, ".nstatus"}, st_ok.size(), 1);
    if (st_ok.size() >= 1) begin
      checkOutput({nm, ".crc_ok"}, 32'(st_ok[0]), 32'(ok));
      checkOutput({nm, ".runt"}, 32'(st_runt[0]), 32'(rn));
    end
    clear_queues();
  endtask

  initial begin
    logic [7:0] pk [$];
    logic [7:0] pay [$];
    logic [7:0] exp [$];
    logic [7:0] chk9 [$];
    int         n;
    bit         bad;
    bit         is_runt;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values in the first cycle after reset.
    @(negedge clk);
    checkOutput("rst.s_ready", 32'(s_ready[0]), 32'd1);
    checkOutput("rst.m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("rst.m_last", 32'(m_last[0]), 32'd0);
    checkOutput("rst.m_data", 32'(m_data[0]), 32'd0);
    checkOutput("rst.status_valid", 32'(status_valid[0]), 32'd0);
    checkOutput("rst.crc_ok", 32'(crc_ok[0]), 32'd0);
    checkOutput("rst.runt", 32'(runt[0]), 32'd0);
    checkOutput("rst.s_ready_b", 32'(s_ready[1]), 32'd1);
    @(posedge clk);
    #1;

    add_vec(0, "123456789", 1, 8'hC2, 8'h44, 0, 1'b1, 1'b0);
    add_vec(0, "123446789", 1, 8'hC2, 8'h44, 0, 1'b0, 1'b0);
    add_vec(0, "",          1, 8'hAA, 8'hBB, 0, 1'b0, 1'b1);
    add_vec(0, "123456789", 1, 8'hC2, 8'h44, 1, 1'b1, 1'b0);
    add_vec(0, "U",         0, 8'h00, 8'h00, 0, 1'b0, 1'b1);
    add_vec(0, "A",         2, 8'h00, 8'h00, 1, 1'b1, 1'b0);
    add_vec(1, "123456789", 1, 8'hFE, 8'hE8, 0, 1'b1, 1'b0);
    add_vec(1, "",          1, 8'h00, 8'h00, 0, 1'b0, 1'b1);
    add_vec(1, "123456789", 1, 8'hFE, 8'hE8, 1, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      sel        = tbl[i].sel;
      stall_mode = tbl[i].stall;
      pk.delete();
      exp.delete();
      for (int k = 0; k < tbl[i].len; k++) pk.push_back(tbl[i].data[k]);
      if (!tbl[i].exp_runt) begin
        for (int k = 0; k < tbl[i].len - 2; k++) exp.push_back(tbl[i].data[k]);
      end
      applyStimulus(pk, 1'b1);
      drain();
      checkPacket($sformatf("vec%0d", i), exp, tbl[i].exp_ok, tbl[i].exp_runt);
    end

    // Back-to-back BUYPASS packets: two passes twelve cycles apart.
    sel        = 1;
    stall_mode = 0;
    chk9.delete();
    for (int k = 0; k < 9; k++) chk9.push_back(8'h31 + 8'(k));
    pk = chk9;
    pk.push_back(8'hFE);
    pk.push_back(8'hE8);
    applyStimulus(pk, 1'b1);
    applyStimulus(pk, 1'b1);
    drain();
    checkOutput("b2b.count", out_d.size(), 18);
    checkOutput("b2b.nstatus", st_ok.size(), 2);
    if (st_ok.size() == 2) begin
      checkOutput("b2b.ok0", 32'(st_ok[0]), 32'd1);
      checkOutput("b2b.ok1", 32'(st_ok[1]), 32'd1);
      checkOutput("b2b.spacing", st_cyc[1] - st_cyc[0], 12);
    end
    n = 0;
    for (int k = 0; k < out_d.size() && k < 18; k++) begin
      if (out_d[k] !== chk9[k % 9] || out_l[k] !== ((k % 9) == 8)) n++;
    end
    checkOutput("b2b.payload_errs", n, 0);
    clear_queues();

    // Reset in the middle of a MAXIM packet, then the full packet again.
    sel = 0;
    pk.delete();
    for (int k = 0; k < 5; k++) pk.push_back(chk9[k]);
    applyStimulus(pk, 1'b0);
    rst          = 1'b1;
    beats_in_pkt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_queues();
    @(negedge clk);
    checkOutput("abort.m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("abort.s_ready", 32'(s_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    drain();
    checkOutput("abort.nstatus", st_ok.size(), 0);
    checkOutput("abort.nbeats", out_d.size(), 0);
    clear_queues();
    pk = chk9;
    pk.push_back(8'hC2);
    pk.push_back(8'h44);
    applyStimulus(pk, 1'b1);
    drain();
    checkPacket("resend", chk9, 1'b1, 1'b0);

    // Randomised packets against the whole-payload reference model.
    for (int r = 0; r < 24; r++) begin
      sel        = $urandom_range(0, 1);
      stall_mode = $urandom_range(0, 1);
      pay.delete();
      is_runt = ($urandom_range(0, 4) == 0);
      if (is_runt) begin
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
        pk = pay;
      end else begin
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
        append_fcs(sel, pay, pk);
      end
      bad = !is_runt && ($urandom_range(0, 2) == 0);
      if (bad) begin
        n = $urandom_range(0, pk.size() - 1);
        pk[n] = pk[n] ^ (8'h01 << $urandom_range(0, 7));
      end
      exp.delete();
      if (!is_runt) begin
        for (int k = 0; k < pk.size() - 2; k++) exp.push_back(pk[k]);
      end
      applyStimulus(pk, 1'b1);
      drain();
      checkPacket($sformatf("rnd%0d", r), exp, !is_runt && !bad, is_runt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
